// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, datapath
// mux selects, ALU operations, instruction fields and exception vectors.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_FETCH0  = 5'd1,
    S_FETCH1  = 5'd2,
    S_DECODE  = 5'd3,
    S_R       = 5'd4,
    S_RWB     = 5'd5,
    S_ADDI    = 5'd6,
    S_IWB     = 5'd7,
    S_MEMADDR = 5'd8,
    S_LW0     = 5'd9,
    S_LW1     = 5'd10,
    S_LWWB    = 5'd11,
    S_SW      = 5'd12,
    S_BEQ     = 5'd13,
    S_JUMP    = 5'd14,
    S_EXC0    = 5'd15,
    S_EXC1    = 5'd16,
    S_EXC2    = 5'd17
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_INV
  } iclass_t;

  typedef enum logic {
    CAUSE_INVALID  = 1'b0,
    CAUSE_OVERFLOW = 1'b1
  } cause_t;

  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;

  localparam logic [1:0] IORD_PC      = 2'd0;
  localparam logic [1:0] IORD_ALUOUT  = 2'd1;
  localparam logic [1:0] IORD_VEC_INV = 2'd2;
  localparam logic [1:0] IORD_VEC_OVF = 2'd3;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  localparam logic [2:0] SRCB_B        = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_IMM      = 3'd2;
  localparam logic [2:0] SRCB_IMM_SHL2 = 3'd3;
  localparam logic [2:0] SRCB_ZERO     = 3'd4;

  localparam logic [2:0] PCSRC_ALU    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_MEMB   = 3'd3;
  localparam logic [2:0] PCSRC_EPC    = 3'd4;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R29 = 2'd2;

  localparam logic [2:0] M2R_ALUOUT = 3'd0;
  localparam logic [2:0] M2R_MDR    = 3'd1;
  localparam logic [2:0] M2R_K227   = 3'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [31:0] VEC_INVALID  = 32'd253;
  localparam logic [31:0] VEC_OVERFLOW = 32'd254;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       ab_wr;
    logic       alu_out_wr;
    logic       mdr_wr;
    logic       epc_wr;
    logic [1:0] iord_sel;
    logic       alu_src_a_sel;
    logic [2:0] alu_src_b_sel;
    logic [2:0] alu_op;
    logic [2:0] pc_src_sel;
    logic [1:0] reg_dst_sel;
    logic [2:0] mem_to_reg_sel;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational instruction classifier: opcode/funct to class, invalid flag,
// R-type ALU operation and whether the instruction traps on overflow.
module ctrl_opcode_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] iclass,
  output logic       invalid,
  output logic [2:0] r_alu_op,
  output logic       ovf_trap
);

  iclass_t cls;

  always_comb begin
    cls      = CLS_INV;
    r_alu_op = ALU_ADD;
    ovf_trap = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin cls = CLS_R; r_alu_op = ALU_ADD; ovf_trap = 1'b1; end
          FN_SUB: begin cls = CLS_R; r_alu_op = ALU_SUB; ovf_trap = 1'b1; end
          FN_AND: begin cls = CLS_R; r_alu_op = ALU_AND; end
          default: cls = CLS_INV;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      default: cls = CLS_INV;
    endcase
  end

  assign iclass  = cls;
  assign invalid = (cls == CLS_INV);

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle Moore control FSM for the 32-bit datapath. Outputs are registered
// from the next state, so they are a pure function of the current state.
//
// state   | meaning
// RESET   | write 227 into $29
// FETCH0  | read IR at PC, PC <= PC+4
// FETCH1  | memory latency, load IR
// DECODE  | load A/B, ALUOut <= branch target, dispatch
// R       | R-type ALU op, overflow check for add/sub
// RWB     | write ALUOut to rd
// ADDI    | A + imm, overflow check
// IWB     | write ALUOut to rt
// MEMADDR | A + imm address for lw/sw
// LW0/LW1 | read data memory, load MDR
// LWWB    | write MDR to rt
// SW      | store B
// BEQ     | compare, conditional PC <= ALUOut
// JUMP    | PC <= jump target
// EXC0    | EPC <= PC-4, read vector by cause
// EXC1    | vector read latency
// EXC2    | PC <= handler byte from memory
module mc_ctrl_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       ab_wr,
  output logic       alu_out_wr,
  output logic       mdr_wr,
  output logic       epc_wr,
  output logic [1:0] iord_sel,
  output logic       alu_src_a_sel,
  output logic [2:0] alu_src_b_sel,
  output logic [2:0] alu_op,
  output logic [2:0] pc_src_sel,
  output logic [1:0] reg_dst_sel,
  output logic [2:0] mem_to_reg_sel,
  output logic [4:0] state_dbg
);

  state_t    state, state_nxt;
  cause_t    cause, cause_nxt;
  ctrl_out_t outs;
  logic [2:0] iclass;
  logic       invalid, ovf_trap;
  logic [2:0] r_alu_op;

  ctrl_opcode_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .iclass   (iclass),
    .invalid  (invalid),
    .r_alu_op (r_alu_op),
    .ovf_trap (ovf_trap)
  );

  function automatic ctrl_out_t outputs_for(state_t s, cause_t c, logic [2:0] rop);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_RESET:   begin o.reg_wr = 1'b1; o.reg_dst_sel = REGDST_R29; o.mem_to_reg_sel = M2R_K227; end
      S_FETCH0:  begin
        o.iord_sel = IORD_PC; o.alu_src_a_sel = SRCA_PC; o.alu_src_b_sel = SRCB_FOUR;
        o.alu_op = ALU_ADD; o.pc_write = 1'b1; o.pc_src_sel = PCSRC_ALU;
      end
      S_FETCH1:  o.ir_wr = 1'b1;
      S_DECODE:  begin
        o.ab_wr = 1'b1; o.alu_src_a_sel = SRCA_PC; o.alu_src_b_sel = SRCB_IMM_SHL2;
        o.alu_op = ALU_ADD; o.alu_out_wr = 1'b1;
      end
      S_R:       begin o.alu_src_a_sel = SRCA_A; o.alu_src_b_sel = SRCB_B; o.alu_op = rop; o.alu_out_wr = 1'b1; end
      S_RWB:     begin o.reg_wr = 1'b1; o.reg_dst_sel = REGDST_RD; o.mem_to_reg_sel = M2R_ALUOUT; end
      S_ADDI, S_MEMADDR: begin
        o.alu_src_a_sel = SRCA_A; o.alu_src_b_sel = SRCB_IMM; o.alu_op = ALU_ADD; o.alu_out_wr = 1'b1;
      end
      S_IWB:     begin o.reg_wr = 1'b1; o.reg_dst_sel = REGDST_RT; o.mem_to_reg_sel = M2R_ALUOUT; end
      S_LW0:     o.iord_sel = IORD_ALUOUT;
      S_LW1:     o.mdr_wr = 1'b1;
      S_LWWB:    begin o.reg_wr = 1'b1; o.reg_dst_sel = REGDST_RT; o.mem_to_reg_sel = M2R_MDR; end
      S_SW:      begin o.iord_sel = IORD_ALUOUT; o.mem_wr = 1'b1; end
      S_BEQ:     begin
        o.alu_src_a_sel = SRCA_A; o.alu_src_b_sel = SRCB_B; o.alu_op = ALU_SUB;
        o.pc_write_cond = 1'b1; o.pc_src_sel = PCSRC_ALUOUT;
      end
      S_JUMP:    begin o.pc_write = 1'b1; o.pc_src_sel = PCSRC_JUMP; end
      S_EXC0:    begin
        o.alu_src_a_sel = SRCA_PC; o.alu_src_b_sel = SRCB_FOUR; o.alu_op = ALU_SUB; o.epc_wr = 1'b1;
        o.iord_sel = (c == CAUSE_OVERFLOW) ? IORD_VEC_OVF : IORD_VEC_INV;
      end
      S_EXC1:    o.iord_sel = (c == CAUSE_OVERFLOW) ? IORD_VEC_OVF : IORD_VEC_INV;
      S_EXC2:    begin o.pc_write = 1'b1; o.pc_src_sel = PCSRC_MEMB; end
      default:   o = '0;
    endcase
    return o;
  endfunction

  // Overflow and the invalid check only matter on the edge leaving DECODE/R/ADDI.
  always_comb begin
    state_nxt = S_RESET;
    cause_nxt = cause;
    case (state)
      S_RESET:  state_nxt = S_FETCH0;
      S_FETCH0: state_nxt = S_FETCH1;
      S_FETCH1: state_nxt = S_DECODE;
      S_DECODE: begin
        if (invalid) begin
          state_nxt = S_EXC0;
          cause_nxt = CAUSE_INVALID;
        end else begin
          case (iclass_t'(iclass))
            CLS_R:           state_nxt = S_R;
            CLS_ADDI:        state_nxt = S_ADDI;
            CLS_LW, CLS_SW:  state_nxt = S_MEMADDR;
            CLS_BEQ:         state_nxt = S_BEQ;
            CLS_J:           state_nxt = S_JUMP;
            default: begin
              state_nxt = S_EXC0;
              cause_nxt = CAUSE_INVALID;
            end
          endcase
        end
      end
      S_R: begin
        if (overflow && ovf_trap) begin
          state_nxt = S_EXC0;
          cause_nxt = CAUSE_OVERFLOW;
        end else begin
          state_nxt = S_RWB;
        end
      end
      S_ADDI: begin
        if (overflow) begin
          state_nxt = S_EXC0;
          cause_nxt = CAUSE_OVERFLOW;
        end else begin
          state_nxt = S_IWB;
        end
      end
      S_MEMADDR: state_nxt = (iclass_t'(iclass) == CLS_LW) ? S_LW0 : S_SW;
      S_LW0:     state_nxt = S_LW1;
      S_LW1:     state_nxt = S_LWWB;
      S_EXC0:    state_nxt = S_EXC1;
      S_EXC1:    state_nxt = S_EXC2;
      S_RWB, S_IWB, S_LWWB, S_SW, S_BEQ, S_JUMP, S_EXC2: state_nxt = S_FETCH0;
      default:   state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cause <= CAUSE_INVALID;
      outs  <= outputs_for(S_RESET, CAUSE_INVALID, ALU_PASS_A);
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      outs  <= outputs_for(state_nxt, cause_nxt, r_alu_op);
    end
  end

  assign pc_write       = outs.pc_write;
  assign pc_write_cond  = outs.pc_write_cond;
  assign mem_wr         = outs.mem_wr;
  assign ir_wr          = outs.ir_wr;
  assign reg_wr         = outs.reg_wr;
  assign ab_wr          = outs.ab_wr;
  assign alu_out_wr     = outs.alu_out_wr;
  assign mdr_wr         = outs.mdr_wr;
  assign epc_wr         = outs.epc_wr;
  assign iord_sel       = outs.iord_sel;
  assign alu_src_a_sel  = outs.alu_src_a_sel;
  assign alu_src_b_sel  = outs.alu_src_b_sel;
  assign alu_op         = outs.alu_op;
  assign pc_src_sel     = outs.pc_src_sel;
  assign reg_dst_sel    = outs.reg_dst_sel;
  assign mem_to_reg_sel = outs.mem_to_reg_sel;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: instruction table expanded into
// per-cycle expected state/output records, plus reset corner sequences.
module tb_mc_ctrl_unit;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic overflow;
  logic pc_write, pc_write_cond, mem_wr, ir_wr, reg_wr, ab_wr, alu_out_wr, mdr_wr, epc_wr;
  logic [1:0] iord_sel, reg_dst_sel;
  logic alu_src_a_sel;
  logic [2:0] alu_src_b_sel, alu_op, pc_src_sel, mem_to_reg_sel;
  logic [4:0] state_dbg;

  always #5 clk = ~clk;

  mc_ctrl_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .mem_wr(mem_wr), .ir_wr(ir_wr),
    .reg_wr(reg_wr), .ab_wr(ab_wr), .alu_out_wr(alu_out_wr), .mdr_wr(mdr_wr), .epc_wr(epc_wr),
    .iord_sel(iord_sel), .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel),
    .alu_op(alu_op), .pc_src_sel(pc_src_sel), .reg_dst_sel(reg_dst_sel),
    .mem_to_reg_sel(mem_to_reg_sel), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            ovf;
    int              n;
    logic [0:6][4:0] seq;
    logic [1:0]      xiord;
    logic [2:0]      rop;
  } vec_t;

  typedef struct {
    logic [4:0]  st;
    logic [25:0] vec;
  } exp_t;

  vec_t tv[12];
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Expected outputs per state, written out directly from the state descriptions.
  function automatic logic [25:0] exp_vec(logic [4:0] s, logic [1:0] xiord, logic [2:0] rop);
    logic pcw, pcwc, memw, irw, regw, abw, aow, mdrw, epcw, sa;
    logic [1:0] iord, rd;
    logic [2:0] sb, op, pcs, m2r;
    {pcw, pcwc, memw, irw, regw, abw, aow, mdrw, epcw, sa} = '0;
    iord = 0; rd = 0; sb = 0; op = 0; pcs = 0; m2r = 0;
    case (s)
      5'd0:  begin regw = 1; rd = 2; m2r = 2; end
      5'd1:  begin sb = 1; op = 1; pcw = 1; end
      5'd2:  irw = 1;
      5'd3:  begin abw = 1; sb = 3; op = 1; aow = 1; end
      5'd4:  begin sa = 1; op = rop; aow = 1; end
      5'd5:  begin regw = 1; rd = 1; end
      5'd6:  begin sa = 1; sb = 2; op = 1; aow = 1; end
      5'd7:  regw = 1;
      5'd8:  begin sa = 1; sb = 2; op = 1; aow = 1; end
      5'd9:  iord = 1;
      5'd10: mdrw = 1;
      5'd11: begin regw = 1; m2r = 1; end
      5'd12: begin iord = 1; memw = 1; end
      5'd13: begin sa = 1; op = 2; pcwc = 1; pcs = 1; end
      5'd14: begin pcw = 1; pcs = 2; end
      5'd15: begin sb = 1; op = 2; epcw = 1; iord = xiord; end
      5'd16: iord = xiord;
      5'd17: begin pcw = 1; pcs = 3; end
      default: ;
    endcase
    return {pcw, pcwc, memw, irw, regw, abw, aow, mdrw, epcw, iord, sa, sb, op, pcs, rd, m2r};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {pc_write, pc_write_cond, mem_wr, ir_wr, reg_wr, ab_wr, alu_out_wr, mdr_wr, epc_wr,
            iord_sel, alu_src_a_sel, alu_src_b_sel, alu_op, pc_src_sel, reg_dst_sel, mem_to_reg_sel};
  endfunction

  task automatic check_cycle(string name, exp_t e);
    total++;
    if (state_dbg !== e.st || dut_vec() !== e.vec) begin
      bad++;
      $display("FAIL %s: state got %0d want %0d, outputs got %h want %h",
               name, state_dbg, e.st, dut_vec(), e.vec);
    end
  endtask

  // Called at a negedge with the DUT in FETCH0; returns at the next FETCH0.
  task automatic run_vec(string name, vec_t v);
    exp_t e;
    opcode = v.op; funct = v.fn; overflow = v.ovf;
    for (int i = 0; i < v.n; i++) begin
      e.st  = v.seq[i];
      e.vec = exp_vec(v.seq[i], v.xiord, v.rop);
      exp_q.push_back(e);
    end
    for (int i = 0; i < v.n; i++) begin
      e = exp_q.pop_front();
      check_cycle($sformatf("%s[%0d]", name, i), e);
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    tv[0]  = '{OP_RTYPE, FN_SUB, 1'b0, 5, {S_FETCH0, S_FETCH1, S_DECODE, S_R, S_RWB, S_RESET, S_RESET}, 2'd0, 3'd2};
    tv[1]  = '{OP_RTYPE, FN_ADD, 1'b1, 7, {S_FETCH0, S_FETCH1, S_DECODE, S_R, S_EXC0, S_EXC1, S_EXC2}, 2'd3, 3'd1};
    tv[2]  = '{6'h3F, 6'h00, 1'b0, 6, {S_FETCH0, S_FETCH1, S_DECODE, S_EXC0, S_EXC1, S_EXC2, S_RESET}, 2'd2, 3'd0};
    tv[3]  = '{OP_LW, 6'h11, 1'b1, 7, {S_FETCH0, S_FETCH1, S_DECODE, S_MEMADDR, S_LW0, S_LW1, S_LWWB}, 2'd0, 3'd0};
    tv[4]  = '{OP_SW, 6'h00, 1'b0, 5, {S_FETCH0, S_FETCH1, S_DECODE, S_MEMADDR, S_SW, S_RESET, S_RESET}, 2'd0, 3'd0};
    tv[5]  = '{OP_BEQ, 6'h00, 1'b1, 4, {S_FETCH0, S_FETCH1, S_DECODE, S_BEQ, S_RESET, S_RESET, S_RESET}, 2'd0, 3'd0};
    tv[6]  = '{OP_J, 6'h00, 1'b0, 4, {S_FETCH0, S_FETCH1, S_DECODE, S_JUMP, S_RESET, S_RESET, S_RESET}, 2'd0, 3'd0};
    tv[7]  = '{OP_RTYPE, FN_AND, 1'b1, 5, {S_FETCH0, S_FETCH1, S_DECODE, S_R, S_RWB, S_RESET, S_RESET}, 2'd0, 3'd3};
    tv[8]  = '{OP_ADDI, 6'h00, 1'b0, 5, {S_FETCH0, S_FETCH1, S_DECODE, S_ADDI, S_IWB, S_RESET, S_RESET}, 2'd0, 3'd0};
    tv[9]  = '{OP_ADDI, 6'h00, 1'b1, 7, {S_FETCH0, S_FETCH1, S_DECODE, S_ADDI, S_EXC0, S_EXC1, S_EXC2}, 2'd3, 3'd0};
    tv[10] = '{OP_RTYPE, 6'h21, 1'b1, 6, {S_FETCH0, S_FETCH1, S_DECODE, S_EXC0, S_EXC1, S_EXC2, S_RESET}, 2'd2, 3'd0};
    tv[11] = '{OP_RTYPE, FN_ADD, 1'b0, 5, {S_FETCH0, S_FETCH1, S_DECODE, S_R, S_RWB, S_RESET, S_RESET}, 2'd0, 3'd1};

    reset = 1'b1; opcode = OP_LW; funct = 6'h00; overflow = 1'b0;
    // Reset held for three edges: RESET state with $29 <= 227 every cycle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      e.st = S_RESET; e.vec = exp_vec(S_RESET, 2'd0, 3'd0);
      check_cycle($sformatf("reset_hold[%0d]", i), e);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    for (int k = 0; k < 12; k++) run_vec($sformatf("vec%0d", k), tv[k]);

    // Reset during LW0 aborts the load with no memory strobe afterwards.
    opcode = OP_LW; funct = 6'h00; overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); @(negedge clk); end
    e.st = S_LW0; e.vec = exp_vec(S_LW0, 2'd0, 3'd0);
    check_cycle("lw_before_reset", e);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    e.st = S_RESET; e.vec = exp_vec(S_RESET, 2'd0, 3'd0);
    check_cycle("reset_in_lw0", e);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    run_vec("beq_after_reset", tv[5]);
    e.st = S_FETCH0; e.vec = exp_vec(S_FETCH0, 2'd0, 3'd0);
    check_cycle("final_fetch0", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multicycle control unit for the 32-bit datapath. A Moore FSM fetches, decodes and executes one instruction at a time. It drives every register write-enable and every datapath mux select, including the 3-bit selects that feed the 5-input 32-bit muxes. It sits beside the datapath, receives the opcode, funct and ALU flags from it, and handles invalid-instruction and overflow exceptions.

## Interface
- No parameters; all encodings are fixed constants in the package.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- overflow  in  1  ALU overflow, combinational, valid in the execute state
- pc_write, pc_write_cond, mem_wr, ir_wr, reg_wr, ab_wr, alu_out_wr, mdr_wr, epc_wr  out  1 each  register/memory write strobes
- iord_sel  out  2  memory address: 0 PC, 1 ALUOut, 2 const 253, 3 const 254
- alu_src_a_sel  out  1  0 PC, 1 A
- alu_src_b_sel  out  3  0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2, 4 zero
- alu_op  out  3  0 PASS_A, 1 ADD, 2 SUB, 3 AND
- pc_src_sel  out  3  0 ALU result, 1 ALUOut, 2 jump target, 3 zero-extended memory byte, 4 EPC
- reg_dst_sel  out  2  0 rt, 1 rd, 2 const 29
- mem_to_reg_sel  out  3  0 ALUOut, 1 MDR, 2 const 227
- state_dbg  out  5  current state encoding

## Operation
- Supported instructions: R-type add (0x20), sub (0x22), and (0x24); addi (0x08); lw (0x23); sw (0x2B); beq (0x04); j (0x02). Any other opcode or funct is invalid.
- All outputs default to 0. Outputs are a pure function of the state.
- RESET: reg_wr=1, reg_dst_sel=2, mem_to_reg_sel=2 (initialises $29 to 227). Next state is FETCH0.
- FETCH0: iord=0, alu_src_a=0, alu_src_b=1, ADD, pc_write=1, pc_src=0.
- FETCH1: ir_wr=1.
- DECODE: ab_wr=1, alu_src_a=0, alu_src_b=3, ADD, alu_out_wr=1 (branch target). Branches to R, ADDI, MEMADDR, BEQ, JUMP or EXC0.
- R: alu_src_a=1, alu_src_b=0, alu_op from funct, alu_out_wr=1.
  - Goes to EXC0 if overflow=1 and funct is add or sub.
  - Otherwise goes to RWB: reg_wr, reg_dst=1, mem_to_reg=0.
- ADDI: alu_src_a=1, alu_src_b=2, ADD, alu_out_wr=1.
  - Goes to EXC0 on overflow.
  - Otherwise goes to IWB: reg_wr, reg_dst=0, mem_to_reg=0.
- MEMADDR: alu_src_a=1, alu_src_b=2, ADD, alu_out_wr=1. Goes to LW0 (lw) or SW (sw).
- LW0: iord=1. LW1: mdr_wr=1. LWWB: reg_wr, reg_dst=0, mem_to_reg=1.
- SW: iord=1, mem_wr=1.
- BEQ: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_src=1. The datapath gates pc_write_cond with its zero flag.
- JUMP: pc_write=1, pc_src=2.
- EXC0: alu_src_a=0, alu_src_b=1, SUB, epc_wr=1 (EPC = PC-4), iord = 2 (invalid) or 3 (overflow).
- EXC1: holds the same iord (memory latency).
- EXC2: pc_write=1, pc_src=3.
- The final state of every instruction path (RWB, IWB, LWWB, SW, BEQ, JUMP, EXC2) returns to FETCH0.
- Internal cause register: loaded in DECODE/R/ADDI when the exception is taken, held through EXC0–EXC2, cleared to 0 on reset.

## Timing
- Cycles per instruction, counted from FETCH0: R/addi 5, lw 7, sw 5, beq 4, j 4, exception path 3 cycles after the detecting state.
- Memory reads are synchronous with 1-cycle latency, hence FETCH1, LW1 and EXC1.
- Reset sampled high at an edge: the state becomes RESET on that edge, regardless of the current state. Mid-instruction strobes stop immediately, so no partial mem_wr or reg_wr follows.
- While reset is held, the FSM stays in RESET with reg_wr=1.
- On the first edge with reset low, the state moves to FETCH0.
- Overflow and the invalid check are sampled only at the edge leaving DECODE/R/ADDI. Overflow in any other state is ignored.
- Overflow on `and` never causes an exception.

## Structure
- Package ctrl_pkg holds:
  - state enum (5-bit);
  - alu_op, iord, alu_src_b, pc_src, reg_dst and mem_to_reg encodings;
  - opcode and funct constants;
  - exception vector addresses 253 and 254.
- One sub-module, ctrl_opcode_decode (combinational): maps opcode/funct to an instruction class, an invalid flag and the R-type alu_op.

## Test plan
- Reset held 3 cycles, then released → reg_wr=1, reg_dst_sel=2, mem_to_reg_sel=2 during reset; state_dbg=FETCH0 one cycle after release.
- opcode 0, funct 0x22, overflow=0 → states FETCH0, FETCH1, DECODE, R, RWB; alu_op=2 in R; reg_wr only in RWB.
- opcode 0, funct 0x20, overflow=1 in R → EXC0 with iord=3 and epc_wr=1, then EXC1, EXC2 with pc_src=3; reg_wr never asserted.
- opcode 0x3F → EXC0 directly after DECODE with iord=2; opcode 0x23 → 7-cycle path with mdr_wr in LW1.
- opcode 0x2B → mem_wr=1 for exactly one cycle in SW; opcode 0x04 → pc_write_cond=1 with pc_src=1 in BEQ; opcode 0x02 → pc_src=2 in JUMP.
- Reset asserted during LW0 → next state RESET, no mem_wr/mdr_wr pulse; decode of a following beq proceeds normally after release.
